pc_branch_ctrl: RTL and testbench
=================================

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 SHALL have ports: Clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Start  input  1  one-cycle pulse that begins program execution.
REQ-004 SHALL have ports: Halt  input  1  decoded halt instruction, valid in RUN.
REQ-005 SHALL have ports: BranchEn  input  1  current instruction is a branch.
REQ-006 SHALL have ports: BranchCond  input  2  00 always, 01 zero set, 10 zero clear, 11 negative set.
REQ-007 SHALL have ports: LutIdx  input  5  branch-target table index from instruction field.
REQ-008 SHALL have ports: FlagIn  input  2  ALU flags, bit1 zero, bit0 negative.
REQ-009 SHALL have ports: FlagWe  input  1  current instruction updates flags (CMP etc.).
REQ-010 SHALL have ports: PC  output  10  current instruction address.
REQ-011 SHALL have ports: FlagQ  output  2  registered flags, same bit order as FlagIn.
REQ-012 SHALL have ports: Done  output  1  high while in HALTED.
REQ-013 SHALL have parameter: PC_W, default 10, program counter width.

Function
REQ-014 SHALL implement states IDLE, RUN, HALTED; state, PC, FlagQ, Done all registered.
REQ-015 IDLE: PC held at 0, Done 0; Start high -> RUN next edge, PC stays 0.
REQ-016 RUN, no Halt, no taken branch: PC <= PC+1 modulo 2^PC_W (1023 -> 0 wrap, no flag, no stall).
REQ-017 RUN, BranchEn and condition true: PC <= LUT[LutIdx] (absolute target), one-cycle latency, no delay slot.
REQ-018 Condition SHALL be evaluated on FlagQ (registered flags) unless REQ-027 applies.
REQ-019 BranchEn with condition false: PC <= PC+1.
REQ-020 RUN, FlagWe high: FlagQ <= FlagIn at the edge; FlagWe ignored in IDLE and HALTED.
REQ-021 RUN, Halt high: -> HALTED next edge, PC holds, Done <= 1; Halt wins over simultaneous BranchEn.
REQ-022 HALTED: PC and FlagQ hold; Start -> RUN with PC <= 0, FlagQ <= 0, Done <= 0.
REQ-023 Start in RUN SHALL be ignored; Halt/BranchEn/FlagWe outside RUN SHALL be ignored.
REQ-024 Flag write and branch in same cycle: flag write lands, branch uses pre-write FlagQ (without REQ-027).

Reset
REQ-025 Reset high SHALL asynchronously force IDLE, PC 0, FlagQ 00, Done 0, including mid-RUN.
REQ-026 First edge after Reset deasserts SHALL behave as IDLE (Start required to run).

Configuration
REQ-027 Macro FLAG_BYPASS_EN defined: when FlagWe and BranchEn are high in the same RUN cycle, the condition uses FlagIn instead of FlagQ; undefined: always FlagQ (REQ-024).

Structure
REQ-028 Shared package SHALL hold state enum, BranchCond encodings (kB_ALW, kB_EQ, kB_NE, kB_LT) and the 32-entry target table constants.
REQ-029 Target table SHALL be a combinational sub-module branch_lut (5-bit index in, PC_W-bit target out); entry 3 = 100, entry 5 = 1023, entry 0 = 0.

Verification
REQ-030 Reset, Start pulse, 5 idle cycles -> PC sequence 0,1,2,3,4,5; Done 0; FlagQ 00.
REQ-031 FlagWe with FlagIn=10, next cycle BranchEn Cond=01 LutIdx=3 -> PC=100 next edge; Cond=10 same flags -> PC+1.
REQ-032 Jump to LutIdx=5 (PC=1023), then sequential -> PC=0 (wrap).
REQ-033 Halt and BranchEn same cycle at PC=7 -> HALTED, PC=7, Done=1; Start -> PC=0, Done=0.
REQ-034 FlagQ=00, same cycle FlagWe FlagIn=01 and BranchEn Cond=11 LutIdx=3 -> PC+1 without FLAG_BYPASS_EN, 100 with it.
REQ-035 Reset asserted mid-RUN between edges at PC=42 -> PC, FlagQ, Done 0 immediately, IDLE held until Start.

Source files
------------

// File: rtl/pc_branch_ctrl_pkg.sv
// Shared types and constants for the PC / branch controller: FSM states,
// branch-condition encodings and the 32-entry absolute branch-target table.
// No logic; imported by the interface-facing top and the target-table sub-module.
package pc_branch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // BranchCond encodings; flag bits are {zero, negative}.
  localparam logic [1:0] kB_ALW = 2'b00;  // unconditional
  localparam logic [1:0] kB_EQ  = 2'b01;  // zero flag set
  localparam logic [1:0] kB_NE  = 2'b10;  // zero flag clear
  localparam logic [1:0] kB_LT  = 2'b11;  // negative flag set

  localparam int kLutDepth = 32;
  localparam int kLutW     = 10;

  // Absolute branch targets indexed by the instruction's LutIdx field.
  // Entries 0, 3 and 5 are fixed by the program image (0, 100, 1023);
  // the rest are spaced 16 apart.
  localparam logic [kLutW-1:0] kBranchTable [0:kLutDepth-1] = '{
    10'd0,   10'd16,  10'd32,  10'd100, 10'd64,  10'd1023, 10'd96,  10'd112,
    10'd128, 10'd144, 10'd160, 10'd176, 10'd192, 10'd208,  10'd224, 10'd240,
    10'd256, 10'd272, 10'd288, 10'd304, 10'd320, 10'd336,  10'd352, 10'd368,
    10'd384, 10'd400, 10'd416, 10'd432, 10'd448, 10'd464,  10'd480, 10'd496
  };

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// Control/status bundle between the instruction decoder and the PC controller.
// Ports: Start/Halt/BranchEn/BranchCond/LutIdx/FlagIn/FlagWe in; PC/FlagQ/Done out.
// master = decoder side (drives controls), slave = pc_branch_ctrl.
interface pc_branch_ctrl_if #(
  parameter int PC_W = 10
) ();

  logic            Start;
  logic            Halt;
  logic            BranchEn;
  logic [1:0]      BranchCond;
  logic [4:0]      LutIdx;
  logic [1:0]      FlagIn;
  logic            FlagWe;
  logic [PC_W-1:0] PC;
  logic [1:0]      FlagQ;
  logic            Done;

  modport master (
    output Start, Halt, BranchEn, BranchCond, LutIdx, FlagIn, FlagWe,
    input  PC, FlagQ, Done
  );

  modport slave (
    input  Start, Halt, BranchEn, BranchCond, LutIdx, FlagIn, FlagWe,
    output PC, FlagQ, Done
  );

endinterface

// File: rtl/pc_branch_ctrl_lut.sv
// branch_lut: combinational branch-target table lookup.
// Latency: zero (pure combinational). No backpressure.
// Ports: idx (5-bit table index) in, target (PC_W-bit absolute address) out.
module branch_lut
  import pc_branch_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [4:0]      idx,
  output logic [PC_W-1:0] target
);

  assign target = PC_W'(kBranchTable[idx]);

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter sequencer with IDLE/RUN/HALTED FSM and
// flag-conditioned absolute branches. Latency: one edge for every PC/flag
// update. No backpressure: a new instruction is accepted every RUN cycle.
// Ports: Clk, Reset (async active-high), bus (pc_branch_ctrl_if.slave).
// Build option: FLAG_BYPASS_EN -- a branch issued in the same cycle as a flag
// write evaluates its condition on FlagIn instead of the registered FlagQ.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  pc_branch_ctrl_if.slave   bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      flag_q, flag_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] lut_target;
  logic [1:0]      cond_flags;
  logic            branch_taken;

  branch_lut #(.PC_W(PC_W)) u_lut (
    .idx    (bus.LutIdx),
    .target (lut_target)
  );

  // Flags the branch condition looks at.
  always_comb begin
    cond_flags = flag_q;
`ifdef FLAG_BYPASS_EN
    // Forward the flag value being written this cycle so a CMP+branch pair
    // sees the fresh result.
    if (bus.FlagWe && bus.BranchEn) begin
      cond_flags = bus.FlagIn;
    end
`endif
  end

  always_comb begin
    branch_taken = 1'b0;
    case (bus.BranchCond)
      kB_ALW:  branch_taken = 1'b1;
      kB_EQ:   branch_taken = cond_flags[1];
      kB_NE:   branch_taken = ~cond_flags[1];
      kB_LT:   branch_taken = cond_flags[0];
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state / next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        pc_d   = '0;
        done_d = 1'b0;
        if (bus.Start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // A flag write lands regardless of branch/halt in the same cycle.
        if (bus.FlagWe) begin
          flag_d = bus.FlagIn;
        end
        if (bus.Halt) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (bus.BranchEn && branch_taken) begin
          pc_d = lut_target;
        end else begin
          pc_d = pc_q + PC_W'(1);  // wraps naturally at 2^PC_W
        end
      end

      ST_HALTED: begin
        if (bus.Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          flag_d  = 2'b00;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        flag_d  = 2'b00;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flag_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign bus.PC    = pc_q;
  assign bus.FlagQ = flag_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed self-checking bench for pc_branch_ctrl: reset, start, sequential
// fetch, conditional branches, wrap, halt priority, flag bypass option and
// asynchronous mid-run reset.
module tb_pc_branch_ctrl;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  pc_branch_ctrl_if #(.PC_W(10)) bus ();

  pc_branch_ctrl #(.PC_W(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start      = 1'b0;
    bus.Halt       = 1'b0;
    bus.BranchEn   = 1'b0;
    bus.BranchCond = 2'b00;
    bus.LutIdx     = 5'd0;
    bus.FlagIn     = 2'b00;
    bus.FlagWe     = 1'b0;
  endtask

  task automatic branch(input logic [1:0] cond, input logic [4:0] idx);
    bus.BranchEn   = 1'b1;
    bus.BranchCond = cond;
    bus.LutIdx     = idx;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    idle_inputs();

    // Reset state
    tick();
    tick();
    chk("rst_pc", bus.PC, 0);
    chk("rst_flag", bus.FlagQ, 0);
    chk("rst_done", bus.Done, 0);

    // First edge after reset release stays in IDLE; control inputs ignored
    Reset = 1'b0;
    bus.Halt = 1'b1;
    branch(2'b00, 5'd3);
    bus.FlagWe = 1'b1;
    bus.FlagIn = 2'b11;
    tick();
    chk("idle_pc", bus.PC, 0);
    chk("idle_done", bus.Done, 0);
    chk("idle_flag", bus.FlagQ, 0);
    idle_inputs();

    // Start pulse: RUN next edge, PC stays 0
    bus.Start = 1'b1;
    tick();
    chk("start_pc", bus.PC, 0);
    bus.Start = 1'b0;

    // Sequential fetch 1..5
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", bus.PC, i);
    end
    chk("seq_done", bus.Done, 0);
    chk("seq_flag", bus.FlagQ, 0);

    // Flag write: zero set
    bus.FlagWe = 1'b1;
    bus.FlagIn = 2'b10;
    tick();
    chk("fw_pc", bus.PC, 6);
    chk("fw_flag", bus.FlagQ, 2'b10);
    idle_inputs();

    // EQ taken -> entry 3
    branch(2'b01, 5'd3);
    tick();
    chk("beq_taken", bus.PC, 100);

    // NE not taken with zero set
    branch(2'b10, 5'd3);
    tick();
    chk("bne_fall", bus.PC, 101);

    // LT not taken (negative clear)
    branch(2'b11, 5'd3);
    tick();
    chk("blt_fall", bus.PC, 102);

    // Unconditional to entry 5, then wrap
    branch(2'b00, 5'd5);
    tick();
    chk("balw_1023", bus.PC, 1023);
    idle_inputs();
    tick();
    chk("wrap_pc", bus.PC, 0);

    // Clear flags, then same-cycle flag write + branch on negative
    bus.FlagWe = 1'b1;
    bus.FlagIn = 2'b00;
    tick();
    chk("clr_flag", bus.FlagQ, 0);
    chk("clr_pc", bus.PC, 1);
    bus.FlagIn = 2'b01;
    branch(2'b11, 5'd3);
    tick();
`ifdef FLAG_BYPASS_EN
    chk("byp_pc", bus.PC, 100);
`else
    chk("byp_pc", bus.PC, 2);
`endif
    chk("byp_flag", bus.FlagQ, 2'b01);

    // Now the registered negative flag is set: LT taken either way
    bus.FlagWe = 1'b0;
    tick();
    chk("blt_taken", bus.PC, 100);
    idle_inputs();

    // Start in RUN is ignored
    bus.Start = 1'b1;
    tick();
    chk("run_start_ign", bus.PC, 101);
    bus.Start = 1'b0;

    // Go to PC=7 via entry 0
    branch(2'b00, 5'd0);
    tick();
    chk("jmp0_pc", bus.PC, 0);
    idle_inputs();
    repeat (7) tick();
    chk("pc7", bus.PC, 7);

    // Halt wins over simultaneous branch
    bus.Halt = 1'b1;
    branch(2'b00, 5'd3);
    tick();
    chk("halt_pc", bus.PC, 7);
    chk("halt_done", bus.Done, 1);
    idle_inputs();

    // HALTED ignores branch / flag write / halt
    branch(2'b00, 5'd5);
    bus.FlagWe = 1'b1;
    bus.FlagIn = 2'b10;
    tick();
    chk("hlt_hold_pc", bus.PC, 7);
    chk("hlt_hold_flag", bus.FlagQ, 2'b01);
    chk("hlt_hold_done", bus.Done, 1);
    idle_inputs();

    // Restart from HALTED
    bus.Start = 1'b1;
    tick();
    chk("restart_pc", bus.PC, 0);
    chk("restart_done", bus.Done, 0);
    chk("restart_flag", bus.FlagQ, 0);
    bus.Start = 1'b0;
    bus.FlagWe = 1'b1;
    bus.FlagIn = 2'b11;
    tick();
    chk("restart_run", bus.PC, 1);
    idle_inputs();

    // Run up to PC=42
    repeat (41) tick();
    chk("pc42", bus.PC, 42);
    chk("pc42_flag", bus.FlagQ, 2'b11);

    // Asynchronous reset between edges
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_pc", bus.PC, 0);
    chk("arst_flag", bus.FlagQ, 0);
    chk("arst_done", bus.Done, 0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    chk("post_arst_idle", bus.PC, 0);
    bus.Start = 1'b1;
    tick();
    chk("post_arst_start", bus.PC, 0);
    bus.Start = 1'b0;
    tick();
    chk("post_arst_run", bus.PC, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
